// File: rtl/mips_mdu_pkg.sv
// Shared constants and types for the MIPS54 multiply/divide unit.
//   WIDTH       : operand/result width of the datapath (32)
//   CNT_W       : iteration counter width, wide enough to hold WIDTH
//   DIV_LATENCY : cycles from the start-accept cycle to the done pulse
//   div_state_e : divider control states
package mips_mdu_pkg;

  localparam int unsigned WIDTH       = 32;
  localparam int unsigned CNT_W       = 6;
  localparam int unsigned DIV_LATENCY = 34;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/mdu_div_iter_step.sv
// One restoring-division iteration: shift the {rem, quo} pair left by one,
// trial-subtract the divisor magnitude and keep the result if non-negative.
//   i_rem : partial remainder (always < i_dsr, so it fits in WIDTH bits)
//   i_quo : quotient/dividend shift register
//   i_dsr : divisor magnitude
//   o_rem : next partial remainder
//   o_quo : next quotient shift register, new bit in the LSB
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dsr,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;
  logic           w_neg;

  // The shifted remainder is < 2*divisor, so bit WIDTH of the WIDTH+1 bit
  // difference is an exact sign flag; a kept remainder never needs bit WIDTH.
  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, i_dsr};
  assign w_neg   = w_trial[WIDTH];

  assign o_rem = w_neg ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], ~w_neg};

endmodule

// File: rtl/mdu_div_iter.sv
// Iterative 32-bit restoring divider for DIV/DIVU. Quotient feeds LO and
// remainder feeds HI. Accepts a start pulse when idle, runs WIDTH iteration
// cycles plus one sign-fix cycle, then pulses done with results valid.
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   start     : request pulse, accepted only when busy=0
//   is_signed : 1=DIV (two's complement), 0=DIVU
//   dividend  : rs operand, latched on accept
//   divisor   : rt operand, latched on accept
//   busy      : operation in progress
//   done      : one-cycle pulse, q/r/div_zero valid
//   div_zero  : divisor was zero, held with results
//   q         : quotient (LO)
//   r         : remainder (HI)
module mdu_div_iter #(
  parameter int unsigned WIDTH = mips_mdu_pkg::WIDTH,
  parameter int unsigned CNT_W = mips_mdu_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  import mips_mdu_pkg::*;

  div_state_e       r_state;
  div_state_e       w_state_nxt;

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dsr_mag;
  logic [WIDTH-1:0] r_dvd_raw;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_dsr_zero;
  logic             r_done;
  logic             r_dz;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  // Operand magnitudes; signs only count for a signed operation.
  assign w_a_neg = is_signed & dividend[WIDTH-1];
  assign w_b_neg = is_signed & divisor[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~dividend + WIDTH'(1)) : dividend;
  assign w_b_mag = w_b_neg ? (~divisor + WIDTH'(1)) : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dsr (r_dsr_mag),
    .o_rem (w_rem_nxt),
    .o_quo (w_quo_nxt)
  );

  // Truncated negation makes 0x80000000 / -1 come out as 0x80000000.
  assign w_q_fix = r_sign_q ? (~r_quo + WIDTH'(1)) : r_quo;
  assign w_r_fix = r_sign_r ? (~r_rem + WIDTH'(1)) : r_rem;

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = ST_CALC;
      end
      ST_CALC: if (r_cnt == CNT_W'(1)) w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rem      <= '0;
      r_quo      <= '0;
      r_dsr_mag  <= '0;
      r_dvd_raw  <= '0;
      r_cnt      <= '0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_dsr_zero <= 1'b0;
      r_done     <= 1'b0;
      r_dz       <= 1'b0;
      r_q        <= '0;
      r_r        <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_rem      <= '0;
            r_quo      <= w_a_mag;
            r_dsr_mag  <= w_b_mag;
            r_dvd_raw  <= dividend;
            r_cnt      <= CNT_W'(WIDTH);
            r_sign_q   <= w_a_neg ^ w_b_neg;
            r_sign_r   <= w_a_neg;
            r_dsr_zero <= (divisor == '0);
          end
        end
        ST_CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        ST_FIX: begin
          // Divide-by-zero has a fixed architectural result regardless of sign.
          r_q    <= r_dsr_zero ? '1 : w_q_fix;
          r_r    <= r_dsr_zero ? r_dvd_raw : w_r_fix;
          r_dz   <= r_dsr_zero;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign done     = r_done;
  assign div_zero = r_dz;
  assign q        = r_q;
  assign r        = r_r;

endmodule

// File: tb/tb_mdu_div_iter.sv
module tb_mdu_div_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] q;
  logic [31:0] r;

  int unsigned total;
  int unsigned bad;

  mdu_div_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .q         (q),
    .r         (r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n cycles; afterwards we sit 1 time unit past a rising edge.
  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called in cycle 0 of an operation; returns in cycle 1 with start low.
  task automatic issue(input logic sg, input logic [31:0] a, input logic [31:0] b);
    is_signed = sg;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    wait_cyc(1);
    start     = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    is_signed = 1'b0;
    dividend = '0;
    divisor = '0;
    wait_cyc(3);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b exp=0", div_zero); end
    total++; if (q !== 32'h0) begin bad++; $display("FAIL reset_q got=%h exp=0", q); end
    total++; if (r !== 32'h0) begin bad++; $display("FAIL reset_r got=%h exp=0", r); end
    rst_n = 1'b1;
    wait_cyc(1);
  endtask

  task automatic test_unsigned;
    issue(1'b0, 32'd100, 32'd7);
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'd3;
    for (int c = 1; c <= 34; c++) begin
      total++;
      if (busy !== (c <= 33)) begin
        bad++; $display("FAIL u100_7_busy cycle=%0d got=%b exp=%b", c, busy, (c <= 33));
      end
      total++;
      if (done !== (c == 34)) begin
        bad++; $display("FAIL u100_7_done cycle=%0d got=%b exp=%b", c, done, (c == 34));
      end
      if (c < 34) wait_cyc(1);
    end
    total++; if (q !== 32'd14) begin bad++; $display("FAIL u100_7_q got=%h exp=%h", q, 32'd14); end
    total++; if (r !== 32'd2) begin bad++; $display("FAIL u100_7_r got=%h exp=%h", r, 32'd2); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL u100_7_dz got=%b exp=0", div_zero); end
    wait_cyc(3);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL hold_done got=%b exp=0", done); end
    total++; if (q !== 32'd14) begin bad++; $display("FAIL hold_q got=%h exp=%h", q, 32'd14); end
    total++; if (r !== 32'd2) begin bad++; $display("FAIL hold_r got=%h exp=%h", r, 32'd2); end

    issue(1'b0, 32'hFFFF_FFFF, 32'd1);
    wait_cyc(33);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL umax_1_done got=%b exp=1", done); end
    total++; if (q !== 32'hFFFF_FFFF) begin bad++; $display("FAIL umax_1_q got=%h exp=ffffffff", q); end
    total++; if (r !== 32'h0) begin bad++; $display("FAIL umax_1_r got=%h exp=0", r); end
  endtask

  task automatic test_signed;
    logic [31:0] ta [3];
    logic [31:0] tb [3];
    logic [31:0] tq [3];
    logic [31:0] tr [3];
    ta = '{32'hFFFF_FFF9, 32'd7,         32'h8000_0000};
    tb = '{32'd2,         32'hFFFF_FFFE, 32'hFFFF_FFFF};
    tq = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000};
    tr = '{32'hFFFF_FFFF, 32'd1,         32'h0};
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, ta[i], tb[i]);
      wait_cyc(33);
      total++; if (done !== 1'b1) begin bad++; $display("FAIL signed%0d_done got=%b exp=1", i, done); end
      total++; if (q !== tq[i]) begin bad++; $display("FAIL signed%0d_q got=%h exp=%h", i, q, tq[i]); end
      total++; if (r !== tr[i]) begin bad++; $display("FAIL signed%0d_r got=%h exp=%h", i, r, tr[i]); end
      total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL signed%0d_dz got=%b exp=0", i, div_zero); end
      wait_cyc(1);
    end
  endtask

  task automatic test_div_zero;
    for (int s = 0; s < 2; s++) begin
      issue(s[0], 32'd1234, 32'd0);
      wait_cyc(32);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL dz%0d_early_done got=%b exp=0", s, done); end
      wait_cyc(1);
      total++; if (done !== 1'b1) begin bad++; $display("FAIL dz%0d_done got=%b exp=1", s, done); end
      total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL dz%0d_flag got=%b exp=1", s, div_zero); end
      total++; if (q !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz%0d_q got=%h exp=ffffffff", s, q); end
      total++; if (r !== 32'd1234) begin bad++; $display("FAIL dz%0d_r got=%h exp=%h", s, r, 32'd1234); end
      wait_cyc(1);
    end
  endtask

  // Leaves the bench in the done cycle so the next test can issue back-to-back.
  task automatic test_ignore_busy;
    issue(1'b0, 32'd100, 32'd7);
    wait_cyc(9);
    issue(1'b1, 32'd50, 32'd5);
    wait_cyc(23);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL ign_done got=%b exp=1", done); end
    total++; if (q !== 32'd14) begin bad++; $display("FAIL ign_q got=%h exp=%h", q, 32'd14); end
    total++; if (r !== 32'd2) begin bad++; $display("FAIL ign_r got=%h exp=%h", r, 32'd2); end
  endtask

  task automatic test_back_to_back;
    issue(1'b0, 32'd50, 32'd5);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_pulse got=%b exp=0", done); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    wait_cyc(33);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b exp=1", done); end
    total++; if (q !== 32'd10) begin bad++; $display("FAIL b2b_q got=%h exp=%h", q, 32'd10); end
    total++; if (r !== 32'd0) begin bad++; $display("FAIL b2b_r got=%h exp=0", r); end
    wait_cyc(1);
  endtask

  task automatic test_reset_midop;
    logic seen;
    issue(1'b0, 32'd100, 32'd7);
    wait_cyc(19);
    rst_n = 1'b0;
    wait_cyc(1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    total++; if (q !== 32'h0) begin bad++; $display("FAIL mid_rst_q got=%h exp=0", q); end
    total++; if (r !== 32'h0) begin bad++; $display("FAIL mid_rst_r got=%h exp=0", r); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL mid_rst_dz got=%b exp=0", div_zero); end
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      wait_cyc(1);
      if (done !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_rst_no_done got=%b exp=0", seen); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_idle got=%b exp=0", busy); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_ignore_busy();
    test_back_to_back();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
